// File: rtl/ir_receiver.sv
// Pulse-distance IR frame receiver: a leader, then 8 data bits sent LSB first, then a stop mark.
// Every level is timed edge to edge. A timing violation aborts the frame with a one-cycle rx_error pulse.
module ir_receiver #(
  parameter int unsigned UNIT_CLKS = 560
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_port,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       busy
);

  localparam int unsigned    CW      = $clog2(16 * UNIT_CLKS + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] T_HALF  = CW'(UNIT_CLKS / 2);
  localparam logic [CW-1:0] T_2U    = CW'(2 * UNIT_CLKS);
  localparam logic [CW-1:0] T_3U    = CW'(3 * UNIT_CLKS);
  localparam logic [CW-1:0] T_4U    = CW'(4 * UNIT_CLKS);
  localparam logic [CW-1:0] T_5U    = CW'(5 * UNIT_CLKS);
  localparam logic [CW-1:0] T_6U    = CW'(6 * UNIT_CLKS);
  localparam logic [CW-1:0] T_10U   = CW'(10 * UNIT_CLKS);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP
  } state_t;

  logic          rx_meta_q, rx_s_q, rx_dly_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_c, rise_c, fall_c, edge_c, in_win;
  logic [CW-1:0] win_lo, win_hi;

  assign rise_c = rx_s_q & ~rx_dly_q;
  assign fall_c = ~rx_s_q & rx_dly_q;
  assign edge_c = rise_c | fall_c;

  always_comb begin
    win_lo = '0;
    win_hi = CNT_MAX;
    case (state_q)
      LEAD_MARK:  begin win_lo = T_6U;   win_hi = T_10U; end
      LEAD_SPACE: begin win_lo = T_3U;   win_hi = T_5U;  end
      BIT_MARK:   begin win_lo = T_HALF; win_hi = T_2U;  end
      BIT_SPACE:  begin win_lo = T_HALF; win_hi = T_4U;  end
      STOP:       begin win_lo = T_HALF; win_hi = T_2U;  end
      default:    ;
    endcase
  end

  assign in_win = (cnt_q >= win_lo) && (cnt_q <= win_hi);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_c     = 1'b0;
    cnt_d     = edge_c ? ONE : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE);

    // Only the edge that ends the current level can arrive, so one window check covers every state.
    if (state_q != IDLE) begin
      if (edge_c && !in_win)
        err_c = 1'b1;
      else if (!edge_c && (cnt_q > win_hi))
        err_c = 1'b1;
    end

    if (err_c) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (fall_c) state_d = LEAD_MARK;
        LEAD_MARK:  if (edge_c) state_d = LEAD_SPACE;
        LEAD_SPACE: if (edge_c) begin
          state_d   = BIT_MARK;
          bit_idx_d = 3'd0;
        end
        BIT_MARK:   if (edge_c) state_d = BIT_SPACE;
        BIT_SPACE:  if (edge_c) begin
          shift_d   = {(cnt_q >= T_2U), shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          state_d   = (bit_idx_q == 3'd7) ? STOP : BIT_MARK;
        end
        STOP:       if (edge_c) begin
          state_d = IDLE;
          data_d  = shift_q;
          valid_d = 1'b1;
        end
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_dly_q  <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_port;
      rx_s_q    <= rx_meta_q;
      rx_dly_q  <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  // The error flag is a decode of the current cycle, so busy stays high while it is shown.
  assign rx_error = err_c & ~reset;
  assign rx_valid = valid_q;
  assign rx_data  = data_q;
  assign busy     = (state_q != IDLE);

endmodule
